// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbitration path.
//   ramstate_t  : status reported by the single-ported RAM.
//   arb_state_t : registered grant of the memory arbiter.
//   word_t      : default machine word.
package cpu_types_pkg;

  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection for the memory arbiter.
// Ports:
//   lock        in  dcache block transfer in progress
//   starve_cnt  in  dcache completions seen while the icache waited
//   iren        in  icache read request
//   dreq        in  dcache request (read or write)
//   next_state  out grant to take at the next clock edge
module arb_pick
  import cpu_types_pkg::*;
#(
  parameter int DSTARVE_MAX = 4,
  parameter int CNT_W       = 3
) (
  input  logic             lock,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic             iren,
  input  logic             dreq,
  output arb_state_t       next_state
);

  always_comb begin
    next_state = IDLE;
    // A locked block transfer outranks the starvation guard so the two
    // words of a dcache block are never separated by an icache access.
    if (lock && dreq) begin
      next_state = DGRANT;
    end else if (iren && (starve_cnt == CNT_W'(DSTARVE_MAX))) begin
      next_state = IGRANT;
    end else if (dreq) begin
      next_state = DGRANT;
    end else if (iren) begin
      next_state = IGRANT;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates icache and dcache word requests onto one single-ported RAM.
// Dcache has priority; the icache is granted after DSTARVE_MAX consecutive
// dcache completions while it waits. Two-word dcache blocks are not split.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   iREN, iaddr              icache request / address
//   iwait, iload             icache wait (low on completion) / returned word
//   dREN, dWEN, daddr, dstore dcache request / address / write data
//   dwait, dload             dcache wait (low on completion) / returned word
//   ramREN, ramWEN, ramaddr, ramstore  RAM command, driven from the grant
//   ramload, ramstate        RAM read data / status
//   err_flag                 sticky, set on any ERROR response while granted
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTARVE_MAX = 4,
  parameter int WORD_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err_flag
);

  localparam int CNT_W = $clog2(DSTARVE_MAX + 1);

  arb_state_t       state_reg, state_next, pick_state;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             lock_reg, lock_next;
  logic             err_flag_reg;

  ramstate_t rs;
  logic      dreq, d_comp, i_comp, d_withdraw, i_withdraw, rearb;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

  // Completion requires the granted client to still be asking; ERROR,
  // BUSY and FREE all leave the request pending.
  assign d_comp     = (state_reg == DGRANT) && dreq && (rs == ACCESS);
  assign i_comp     = (state_reg == IGRANT) && iREN && (rs == ACCESS);
  assign d_withdraw = (state_reg == DGRANT) && !dreq;
  assign i_withdraw = (state_reg == IGRANT) && !iREN;
  assign rearb      = (state_reg == IDLE) || d_comp || i_comp || d_withdraw || i_withdraw;

  always_comb begin
    lock_next = lock_reg;
    if (d_comp && !daddr[2]) begin
      lock_next = 1'b1;
    end
    if ((d_comp || i_comp) && daddr[2]) begin
      lock_next = 1'b0;
    end
    if (!dreq) begin
      lock_next = 1'b0;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (d_comp && iREN && (starve_cnt_reg != CNT_W'(DSTARVE_MAX))) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
    if (i_comp || !iREN) begin
      starve_cnt_next = '0;
    end
  end

  // The pick sees the lock/counter values updated by this cycle's
  // completion, so a finished first block word or a fourth dcache word
  // steers the very next grant with no extra cycle.
  arb_pick #(
    .DSTARVE_MAX(DSTARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .lock      (lock_next),
    .starve_cnt(starve_cnt_next),
    .iren      (iREN),
    .dreq      (dreq),
    .next_state(pick_state)
  );

  assign state_next = rearb ? pick_state : state_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      lock_reg       <= 1'b0;
      err_flag_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      lock_reg       <= lock_next;
      if ((state_reg != IDLE) && (rs == ERROR)) begin
        err_flag_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_reg)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: begin
      end
    endcase
  end

  assign dwait    = ~d_comp;
  assign iwait    = ~i_comp;
  assign dload    = (d_comp && !dWEN) ? ramload : '0;
  assign iload    = i_comp ? ramload : '0;
  assign err_flag = err_flag_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        err_flag;

  memory_arbiter #(.DSTARVE_MAX(4), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_flag(err_flag)
  );

  // RAM read data model: address xor a fixed pattern.
  assign ramload = ramaddr ^ 32'hA5A5_0000;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          seq;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] store;
    logic        ren;
    logic        wen;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int   checks   = 0;
  int   errors   = 0;
  int   push_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] store, input logic ren, input logic wen);
    exp_t e;
    e.seq = push_cnt; e.addr = addr; e.data = data; e.store = store; e.ren = ren; e.wen = wen;
    push_cnt++;
    if (is_d) dq.push_back(e); else iq.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Waits (bounded) for the chosen client's completion; returns just after
  // the clock edge that follows the completion cycle.
  task automatic wait_done(input bit is_d, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge CLK);
      if (is_d ? (dwait == 1'b0) : (iwait == 1'b0)) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no completion within %0d cycles", is_d ? "dcache" : "icache", budget);
    end
  endtask

  task automatic go_idle();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    tick(); tick();
  endtask

  // Scoreboard monitor.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (!dwait) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dwait: dwait got 0 expected 1 at ramaddr %h", ramaddr);
        end else begin
          e = dq.pop_front();
          chk("dload", dload, e.data);
          chk("d_ramaddr", ramaddr, e.addr);
          chk("d_ramstore", ramstore, e.store);
          chk("d_ramREN", {31'd0, ramREN}, {31'd0, e.ren});
          chk("d_ramWEN", {31'd0, ramWEN}, {31'd0, e.wen});
          chk("d_order", done_cnt, e.seq);
          done_cnt++;
        end
      end else begin
        chk("dload_quiet", dload, 32'd0);
      end
      if (!iwait) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_iwait: iwait got 0 expected 1 at ramaddr %h", ramaddr);
        end else begin
          e = iq.pop_front();
          chk("iload", iload, e.data);
          chk("i_ramaddr", ramaddr, e.addr);
          chk("i_ramstore", ramstore, 32'd0);
          chk("i_ramREN", {31'd0, ramREN}, {31'd0, e.ren});
          chk("i_ramWEN", {31'd0, ramWEN}, {31'd0, e.wen});
          chk("i_order", done_cnt, e.seq);
          done_cnt++;
        end
      end else begin
        chk("iload_quiet", iload, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with both clients requesting.
    RST = 1; iREN = 1; dREN = 1; dWEN = 0;
    iaddr = 32'h100; daddr = 32'h200; dstore = 0; ramstate = BUSY;
    @(posedge CLK); @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
    tick();
    RST = 0;
    tick();
    @(negedge CLK);
    chk("dgrant_ramREN", {31'd0, ramREN}, 32'd1);
    chk("dgrant_ramaddr", ramaddr, 32'h200);

    // Simultaneous requests: dcache first after 2 BUSY cycles, then icache.
    push_exp(1, 32'h200, 32'hA5A5_0200, 32'd0, 1'b1, 1'b0);
    push_exp(0, 32'h100, 32'hA5A5_0100, 32'd0, 1'b1, 1'b0);
    tick();
    @(negedge CLK);
    chk("busy_dwait", {31'd0, dwait}, 32'd1);
    tick();
    ramstate = ACCESS;
    wait_done(1, 3);
    dREN = 0;
    wait_done(0, 6);
    go_idle();

    // Block lock with the starvation counter reaching its limit mid-block.
    iREN = 1; iaddr = 32'h300;
    dWEN = 1; daddr = 32'h4C; dstore = 32'h11; ramstate = ACCESS;
    for (int k = 0; k < 3; k++) push_exp(1, 32'h4C, 32'd0, 32'h11, 1'b0, 1'b1);
    push_exp(1, 32'h40, 32'hA5A5_0040, 32'h11, 1'b1, 1'b0);
    push_exp(1, 32'h44, 32'hA5A5_0044, 32'h11, 1'b1, 1'b0);
    push_exp(0, 32'h300, 32'hA5A5_0300, 32'd0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) wait_done(1, 3);
    dWEN = 0; dREN = 1; daddr = 32'h40;
    wait_done(1, 3);
    daddr = 32'h44;
    wait_done(1, 3);
    dREN = 0;
    wait_done(0, 4);
    go_idle();

    // Starvation: six single-word writes; icache enters after the fourth.
    iREN = 1; iaddr = 32'h500; dWEN = 1; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) push_exp(1, 32'h604 + 32'(8 * k), 32'd0, 32'h1000 + 32'(k), 1'b0, 1'b1);
    push_exp(0, 32'h500, 32'hA5A5_0500, 32'd0, 1'b1, 1'b0);
    for (int k = 4; k < 6; k++) push_exp(1, 32'h604 + 32'(8 * k), 32'd0, 32'h1000 + 32'(k), 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      daddr = 32'h604 + 32'(8 * k);
      dstore = 32'h1000 + 32'(k);
      wait_done(1, 4);
    end
    go_idle();

    // ERROR responses: write held and retried, sticky error flag.
    dWEN = 1; daddr = 32'h704; dstore = 32'hDEAD; ramstate = ERROR;
    push_exp(1, 32'h704, 32'd0, 32'hDEAD, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("err_dwait", {31'd0, dwait}, 32'd1);
      chk("err_ramWEN", {31'd0, ramWEN}, 32'd1);
      chk("err_flag_rise", {31'd0, err_flag}, (k > 0) ? 32'd1 : 32'd0);
      tick();
    end
    ramstate = ACCESS;
    wait_done(1, 2);
    go_idle();
    @(negedge CLK);
    chk("err_flag_sticky", {31'd0, err_flag}, 32'd1);

    // Withdrawal before ACCESS: enables drop, no completion, back to IDLE.
    dREN = 1; daddr = 32'h800; ramstate = BUSY;
    tick();
    @(negedge CLK);
    chk("wd_grant_ramREN", {31'd0, ramREN}, 32'd1);
    tick();
    dREN = 0; ramstate = ACCESS;
    @(negedge CLK);
    chk("wd_ramREN", {31'd0, ramREN}, 32'd0);
    chk("wd_dwait", {31'd0, dwait}, 32'd1);
    tick();
    @(negedge CLK);
    chk("wd_idle_ramaddr", ramaddr, 32'd0);
    go_idle();

    chk("dq_drained", dq.size(), 32'd0);
    chk("iq_drained", iq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the icache and dcache.
- Arbitrates their word requests onto the single-ported RAM, returns load data, and drives iwait/dwait back to each cache.
- Dcache normally has priority. Icache is protected from starvation by a bounded fairness counter.
- A dcache two-word block transfer is never split by an icache access.

Parameters:
- DSTARVE_MAX, 4: consecutive dcache completions allowed while iREN is pending before icache gets priority.
- WORD_W, 32: data and address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  WORD_W  icache word address.
- iwait  out  1  icache wait; low exactly in the cycle iload is valid.
- iload  out  WORD_W  instruction word returned to the icache.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  WORD_W  dcache word address.
- dstore  in  WORD_W  dcache write data.
- dwait  out  1  dcache wait; low exactly in the completion cycle.
- dload  out  WORD_W  data word returned to the dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err_flag  out  1  sticky; set on any ERROR response.

Behaviour:
- Reset, only on a rising CLK edge with RST=1:
  - state=IDLE, starve_cnt=0, lock=0, err_flag=0.
  - Consequences: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
  - A reset during an access abandons it; the RAM sees enables drop in the following cycle.
- States: IDLE, DGRANT, IGRANT, held in a registered grant.
  - RAM signals are driven combinationally from the granted client only.
  - In IDLE, all RAM enables and RAM address/data outputs are 0.
  - Arbitration is one registered cycle: a request seen in IDLE gets its RAM enable in the next cycle.
- DGRANT drive:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN & ~dWEN (write wins if both are high).
- IGRANT drive:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
- Completion:
  - Occurs when ramstate==ACCESS in a grant state.
  - That cycle, the granted client's wait=0 and its load=ramload (dload on a dcache read, iload on an icache read).
  - The non-granted wait stays 1. Load outputs are 0 when not completing.
- Re-arbitration happens on completion, on request withdrawal, and every cycle in IDLE. Next-state priority:
  1. lock=1 and dcache requesting -> DGRANT.
  2. iREN and starve_cnt==DSTARVE_MAX -> IGRANT.
  3. dREN|dWEN -> DGRANT.
  4. iREN -> IGRANT.
  5. Otherwise -> IDLE.
- Lock:
  - Set on dcache completion with daddr[2]==0; cleared on any completion with daddr[2]==1.
  - Cleared if the dcache withdraws its request.
- starve_cnt:
  - Increments, saturating at DSTARVE_MAX, on each dcache completion while iREN=1.
  - Clears on icache completion or when iREN=0.
- Request withdrawn while granted (e.g. DGRANT and dREN=dWEN=0): enables drop combinationally that cycle; re-arbitrate next edge.
- BUSY/FREE while granted: hold state; the client's wait stays 1.
- ERROR: treat as no completion; wait stays 1, request is held (retried), err_flag is set and stays set until reset.
- Address or data change mid-grant passes straight through to the RAM; the arbiter does not latch it.
- Back-to-back: a completion in cycle N with a new grant chosen gives RAM enables for the new client in cycle N+1, with no IDLE bubble.

Decomposition:
- cpu_types_pkg: ramstate_t (FREE/BUSY/ACCESS/ERROR), arb_state_t (IDLE/DGRANT/IGRANT), word_t.
- One combinational sub-module, arb_pick: takes lock, starve_cnt, and the request bits and returns the next arb_state_t.
- The FSM, counters and muxes stay in memory_arbiter.

Test Plan:
- Reset: RST=1 for 2 cycles with iREN=dREN=1 -> ramREN=0, iwait=dwait=1, err_flag=0; release -> DGRANT next cycle, ramaddr=daddr.
- Simultaneous: iREN=1 iaddr=0x100, dREN=1 daddr=0x200, ramstate ACCESS after 2 BUSY cycles -> dwait low once with dload=ramload; then IGRANT and iwait low with iload=ramload for 0x100.
- Block lock: dREN at daddr=0x40 then 0x44 with iREN=1 and starve_cnt=DSTARVE_MAX -> both dcache words complete before any icache grant.
- Starvation: dcache issues 6 single-word writes (daddr[2]=1) while iREN=1 -> icache is granted after exactly 4 dcache completions; ramREN=1 and ramWEN=0 during IGRANT.
- Error: DGRANT write, ramstate=ERROR for 3 cycles then ACCESS -> dwait stays 1 throughout ERROR, ramWEN held, err_flag=1 remains after completion.
- Withdrawal: grant dcache, drop dREN before ACCESS -> ramREN=0 that cycle, state IDLE next edge, no dwait pulse.
